// File: rtl/uart_tx_byte.sv
// uart_tx_byte: async serial transmitter for one byte per request.
// Frame on the wire: start(0), 8 data bits LSB first, optional parity, stop(1).
// Every bit is held for exactly CLKS_PER_BIT clocks by an internal baud counter.
//
// Handshake: TX_START is a level request that is only looked at while the
// transmitter is idle; the accepting clock edge latches TX_DATO, and TX_BUSY
// rises on the following cycle. TX_DONE pulses for one cycle (the first idle
// cycle) when the stop bit completes, and TX_BUSY falls in that same cycle, so
// a request held during the TX_DONE cycle starts the next frame on the next edge.
module uart_tx_byte #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned PARITY       = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TX_START,
  input  logic [7:0] TX_DATO,
  output logic       TX,
  output logic       TX_BUSY,
  output logic       TX_DONE
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  // PARITY 1 = even, 2 = odd; anything else (including 3) means no parity bit.
  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic             par_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic             bit_end;

  // Last clock of the current bit period; the counter wraps here.
  always_comb begin
    bit_end = (cnt_q == CNT_LAST);
  end

  // Frame sequencer: the line level for the next bit is registered at the
  // bit boundary so TX never depends combinationally on any input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (TX_START) begin
            shift_q <= TX_DATO;
            par_q   <= (^TX_DATO) ^ PAR_ODD;
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q   <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (idx_q == 3'd7) begin
              if (PAR_EN) begin
                tx_q    <= par_q;
                state_q <= S_PAR;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              tx_q  <= shift_q[1];
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_PAR: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign TX      = tx_q;
  assign TX_BUSY = busy_q;
  assign TX_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_byte.sv
// Bench for uart_tx_byte: three instances (PARITY 0, 1, 2) at 4 clocks/bit.
// Drivers push the expected wire frame at the accept edge; one monitor per
// instance decodes the line, checks bit timing, and pops/compares.
module tb_uart_tx_byte;

  localparam int C = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2:0] start_v;
  logic [7:0] data_v [3];
  logic [2:0] tx_w;
  logic [2:0] busy_w;
  logic [2:0] done_w;

  int n_tests = 0;
  int n_fail  = 0;

  // expected frames, bit 0 is the first bit on the wire
  logic [10:0] exp_q0[$];
  logic [10:0] exp_q1[$];
  logic [10:0] exp_q2[$];

  uart_tx_byte #(.CLKS_PER_BIT(C), .PARITY(0)) u_dut0 (
    .clk(clk), .reset(reset), .TX_START(start_v[0]), .TX_DATO(data_v[0]),
    .TX(tx_w[0]), .TX_BUSY(busy_w[0]), .TX_DONE(done_w[0]));
  uart_tx_byte #(.CLKS_PER_BIT(C), .PARITY(1)) u_dut1 (
    .clk(clk), .reset(reset), .TX_START(start_v[1]), .TX_DATO(data_v[1]),
    .TX(tx_w[1]), .TX_BUSY(busy_w[1]), .TX_DONE(done_w[1]));
  uart_tx_byte #(.CLKS_PER_BIT(C), .PARITY(2)) u_dut2 (
    .clk(clk), .reset(reset), .TX_START(start_v[2]), .TX_DATO(data_v[2]),
    .TX(tx_w[2]), .TX_BUSY(busy_w[2]), .TX_DONE(done_w[2]));

  // instance k is built with PARITY = k
  function automatic int par_of(int idx);
    return idx;
  endfunction

  function automatic int nbits_of(int idx);
    return (par_of(idx) == 0) ? 10 : 11;
  endfunction

  // reference frame built from the byte by counting ones
  function automatic logic [10:0] frame_bits(logic [7:0] d, int par);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    f = '0;
    f[8:1] = d;
    if (par == 1 || par == 2) begin
      f[9]  = (par == 1) ? (ones % 2 == 1) : (ones % 2 == 0);
      f[10] = 1'b1;
    end else begin
      f[9] = 1'b1;
    end
    return f;
  endfunction

  task automatic check(string name, int idx, logic [10:0] got, logic [10:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[u%0d]: got %0h expected %0h at %0t", name, idx, got, exp, $time);
    end
  endtask

  task automatic push_exp(int idx, logic [10:0] v);
    case (idx)
      0: exp_q0.push_back(v);
      1: exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  function automatic int qsize(int idx);
    case (idx)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic pop_exp(int idx, output logic [10:0] v);
    case (idx)
      0: v = exp_q0.pop_front();
      1: v = exp_q1.pop_front();
      default: v = exp_q2.pop_front();
    endcase
  endtask

  task automatic clear_exp(int idx);
    case (idx)
      0: exp_q0.delete();
      1: exp_q1.delete();
      default: exp_q2.delete();
    endcase
  endtask

  // scoreboard monitor: decode one frame per start bit, sampling on negedges
  task automatic monitor(int idx);
    int nb;
    logic [10:0] got;
    logic [10:0] exp;
    bit stable;
    bit busy_ok;
    bit aborted;
    nb = nbits_of(idx);
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("idle_done", idx, 11'(done_w[idx]), 11'd0);
        if (tx_w[idx] == 1'b0) begin
          got = '0;
          stable = 1'b1;
          busy_ok = 1'b1;
          aborted = 1'b0;
          for (int s = 0; s < nb * C; s++) begin
            if (s > 0) @(negedge clk);
            if (reset) begin
              aborted = 1'b1;
              break;
            end
            if (s % C == 0) got[s / C] = tx_w[idx];
            else if (tx_w[idx] !== got[s / C]) stable = 1'b0;
            if (busy_w[idx] !== 1'b1 || done_w[idx] !== 1'b0) busy_ok = 1'b0;
          end
          if (!aborted) begin
            @(negedge clk);
            if (!reset) begin
              check("bit_hold", idx, 11'(stable), 11'd1);
              check("busy_in_frame", idx, 11'(busy_ok), 11'd1);
              check("done_busy_tx_at_end", idx, {8'd0, done_w[idx], busy_w[idx], tx_w[idx]}, 11'b101);
              if (qsize(idx) == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_frame[u%0d]: got %0h expected no frame at %0t", idx, got, $time);
              end else begin
                pop_exp(idx, exp);
                check("frame", idx, got, exp);
              end
            end
          end
        end
      end
    end
  endtask

  // driver: call at a negedge; request is accepted on the next posedge
  task automatic send(int idx, logic [7:0] d);
    start_v[idx] = 1'b1;
    data_v[idx]  = d;
    @(posedge clk);
    push_exp(idx, frame_bits(d, par_of(idx)));
    #1 start_v[idx] = 1'b0;
  endtask

  // wait for TX_DONE after an accept; mode 1 scrambles TX_DATO every cycle,
  // mode 2 pulses a TX_START with 8'h55 mid-frame. Returns at a negedge.
  task automatic wait_done(int idx, int mode);
    int n;
    n = 0;
    while (done_w[idx] !== 1'b1 && n < 12 * C + 4) begin
      @(negedge clk);
      n++;
      if (n == 1) check("accept_latency", idx, {9'd0, busy_w[idx], tx_w[idx]}, 11'b10);
      if (mode == 1) data_v[idx] = 8'($urandom);
      if (mode == 2 && n == 10) begin
        start_v[idx] = 1'b1;
        data_v[idx]  = 8'h55;
      end
      if (mode == 2 && n == 11) start_v[idx] = 1'b0;
    end
    check("done_seen", idx, 11'(done_w[idx]), 11'd1);
    check("done_latency", idx, 11'(n), 11'(nbits_of(idx) * C + 1));
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      fork
        automatic int kk = k;
        monitor(kk);
      join_none
    end
  end

  initial begin
    logic [7:0] d;
    reset   = 1'b1;
    start_v = '0;
    for (int k = 0; k < 3; k++) data_v[k] = 8'd0;
    repeat (3) @(negedge clk);
    check("reset_tx", 0, 11'(tx_w), 11'd7);
    check("reset_busy", 0, 11'(busy_w), 11'd0);
    check("reset_done", 0, 11'(done_w), 11'd0);
    reset = 1'b0;

    for (int idx = 0; idx < 3; idx++) begin
      @(negedge clk);
      send(idx, 8'hA5);
      wait_done(idx, 0);
      @(negedge clk);
      send(idx, 8'h07);
      wait_done(idx, 0);

      // back-to-back: request during the TX_DONE cycle
      @(negedge clk);
      send(idx, 8'hFF);
      wait_done(idx, 0);
      send(idx, 8'h3C);
      wait_done(idx, 0);

      // request while busy is dropped
      repeat (2) @(negedge clk);
      send(idx, 8'h00);
      wait_done(idx, 2);
      repeat (24 * C) @(negedge clk);
      check("idle_after_ignore", idx, {9'd0, busy_w[idx], tx_w[idx]}, 11'b01);

      // TX_DATO churn after accept
      send(idx, 8'hC3);
      wait_done(idx, 1);

      // TX_START held high: frames chain, each resampling TX_DATO
      @(negedge clk);
      d = 8'($urandom);
      data_v[idx]  = d;
      start_v[idx] = 1'b1;
      for (int f = 0; f < 3; f++) begin
        @(posedge clk);
        push_exp(idx, frame_bits(d, par_of(idx)));
        #1 data_v[idx] = 8'($urandom);
        wait_done(idx, 0);
        if (f < 2) begin
          d = 8'($urandom);
          data_v[idx] = d;
        end else begin
          start_v[idx] = 1'b0;
        end
      end

      // random bytes with random gaps
      for (int r = 0; r < 6; r++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send(idx, 8'($urandom));
        wait_done(idx, 0);
      end

      // reset during data bit 3
      @(negedge clk);
      send(idx, 8'($urandom));
      repeat (16) @(posedge clk);
      #2 reset = 1'b1;
      #1 check("reset_midframe", idx, {8'd0, done_w[idx], busy_w[idx], tx_w[idx]}, 11'b001);
      clear_exp(idx);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int w = 0; w < 12 * C; w++) begin
        @(negedge clk);
        check("quiet_after_reset", idx, {8'd0, done_w[idx], busy_w[idx], tx_w[idx]}, 11'b001);
      end
      send(idx, 8'h81);
      wait_done(idx, 0);
    end

    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) check("leftover_expected", k, 11'(qsize(k)), 11'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
